// File: rtl/spi_dma_pump_if.sv
// spi_dma_pump_if: host, memory-bus and SPI data-port signals of the block pump
interface spi_dma_pump_if #(
    parameter int AW     = 16,
    parameter int NBLK_W = 4
);
    logic              start;
    logic              abort;
    logic              dir;
    logic [AW-1:0]     iaddr;
    logic [NBLK_W-1:0] nblocks;
    logic              ready;
    logic              done;
    logic [AW-1:0]     oaddr;
    logic [7:0]        odata;
    logic              owren;
    logic [7:0]        idata;
    logic [7:0]        ospi_data;
    logic              ospi_wr;
    logic [7:0]        ispi_data;
    logic              ispi_dsr;
    logic [NBLK_W-1:0] oblocks;

    modport master (
        output start, abort, dir, iaddr, nblocks, idata, ispi_data, ispi_dsr,
        input  ready, done, oaddr, odata, owren, ospi_data, ospi_wr, oblocks
    );

    modport slave (
        input  start, abort, dir, iaddr, nblocks, idata, ispi_data, ispi_dsr,
        output ready, done, oaddr, odata, owren, ospi_data, ospi_wr, oblocks
    );
endinterface

// File: rtl/spi_dma_pump.sv
// spi_dma_pump: moves nblocks blocks between SPI and memory, with per-block trailer bytes
module spi_dma_pump #(
    parameter int         AW          = 16,
    parameter int         BLOCK_BYTES = 512,
    parameter int         NBLK_W      = 4,
    parameter int         TRAILER     = 2,
    parameter logic [7:0] FILL        = 8'hFF
) (
    input logic           clk,
    input logic           reset_n,
    input logic           ce,
    spi_dma_pump_if.slave bus
);
    localparam int CW = $clog2(BLOCK_BYTES);
    localparam int TW = TRAILER > 1 ? $clog2(TRAILER) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, ISSUE, GUARD, WAIT, STORE} state_t;

    state_t        state;
    logic          dir_q;
    logic          in_trl;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tcnt;
    logic          fin;
    logic          data_last;
    logic          blk_end;
    logic          last_blk;
    logic          to_fetch;

    // byte-completion decode: which byte just finished and where the next one starts
    always_comb begin
        fin       = (state == STORE) || (state == WAIT && bus.ispi_dsr && (in_trl || dir_q));
        data_last = !in_trl && cnt == CW'(BLOCK_BYTES - 1);
        blk_end   = in_trl ? int'(tcnt) == TRAILER - 1 : data_last && TRAILER == 0;
        last_blk  = bus.oblocks == NBLK_W'(1);
        to_fetch  = dir_q && (blk_end || (!in_trl && !data_last));
    end

    // transfer FSM with registered strobes, address and counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            dir_q         <= 1'b0;
            in_trl        <= 1'b0;
            cnt           <= '0;
            tcnt          <= '0;
            bus.ready     <= 1'b1;
            bus.done      <= 1'b0;
            bus.oaddr     <= '0;
            bus.odata     <= '0;
            bus.owren     <= 1'b0;
            bus.ospi_data <= FILL;
            bus.ospi_wr   <= 1'b0;
            bus.oblocks   <= '0;
        end else if (ce) begin
            bus.owren   <= 1'b0;
            bus.ospi_wr <= 1'b0;
            bus.done    <= 1'b0;
            if (bus.abort) begin
                state       <= IDLE;
                bus.ready   <= 1'b1;
                bus.oblocks <= '0;
            end else begin
                case (state)
                    IDLE: if (bus.start) begin
                        dir_q       <= bus.dir;
                        bus.oaddr   <= bus.iaddr;
                        bus.oblocks <= bus.nblocks;
                        cnt         <= '0;
                        tcnt        <= '0;
                        in_trl      <= 1'b0;
                        bus.ready   <= bus.nblocks == '0;
                        bus.done    <= bus.nblocks == '0;
                        bus.ospi_wr <= bus.nblocks != '0 && !bus.dir;
                        if (!bus.dir) bus.ospi_data <= FILL;
                        state <= bus.nblocks == '0 ? IDLE : bus.dir ? FETCH : ISSUE;
                    end
                    FETCH: state <= LATCH;
                    LATCH: begin
                        bus.ospi_data <= bus.idata;
                        bus.ospi_wr   <= 1'b1;
                        bus.oaddr     <= bus.oaddr + 1'b1;
                        state         <= ISSUE;
                    end
                    ISSUE: state <= GUARD;
                    GUARD: state <= WAIT;
                    WAIT: if (bus.ispi_dsr && !fin) begin
                        bus.owren <= 1'b1;
                        bus.odata <= bus.ispi_data;
                        state     <= STORE;
                    end
                    STORE: bus.oaddr <= bus.oaddr + 1'b1;
                    default: state <= IDLE;
                endcase
                if (fin) begin
                    if (!in_trl) cnt <= cnt + 1'b1;
                    if (blk_end) begin
                        in_trl      <= 1'b0;
                        bus.oblocks <= bus.oblocks - 1'b1;
                    end else if (data_last) begin
                        in_trl <= 1'b1;
                        tcnt   <= '0;
                    end else if (in_trl) begin
                        tcnt <= tcnt + 1'b1;
                    end
                    if (blk_end && last_blk) begin
                        bus.done  <= 1'b1;
                        bus.ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        state       <= to_fetch ? FETCH : ISSUE;
                        bus.ospi_wr <= !to_fetch;
                        if (!to_fetch) bus.ospi_data <= FILL;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_dma_pump.sv
// tb_spi_dma_pump: randomized block transfers checked against a per-transfer byte-list model
module tb_spi_dma_pump;
    localparam int BB = 4;
    localparam int TR = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ce = 1'b1;

    spi_dma_pump_if #(.AW(16), .NBLK_W(4)) bus();

    spi_dma_pump #(.AW(16), .BLOCK_BYTES(BB), .NBLK_W(4), .TRAILER(TR), .FILL(8'hFF)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:65535];
    logic [23:0] wr_q [$];
    logic [7:0]  spi_q [$];
    int          done_cnt = 0;
    int          total = 0;
    int          bad = 0;
    bit          ce_rand = 1'b0;
    bit          ce_off = 1'b0;
    bit          dly_rand = 1'b0;
    bit          stall = 1'b0;
    int          busy;
    logic [7:0]  rx_n;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // synchronous memory read port and SPI slave returning 8'h10+n for the n-th byte
    always @(posedge clk) begin
        if (ce) bus.idata <= mem[bus.oaddr];
        if (!reset_n) begin
            bus.ispi_dsr  <= 1'b1;
            bus.ispi_data <= 8'h00;
            busy          <= 0;
            rx_n          <= 8'h10;
        end else if (ce) begin
            if (bus.ospi_wr) begin
                bus.ispi_dsr <= 1'b0;
                busy         <= dly_rand ? int'($urandom_range(0, 3)) : 0;
            end else if (!bus.ispi_dsr && !stall) begin
                if (busy == 0) begin
                    bus.ispi_dsr  <= 1'b1;
                    bus.ispi_data <= rx_n;
                    rx_n          <= rx_n + 8'd1;
                end else begin
                    busy <= busy - 1;
                end
            end
        end
    end

    // strobe monitor away from the active edge, then pick ce for the next edge
    always @(negedge clk) begin
        if (ce && reset_n) begin
            if (bus.owren) wr_q.push_back({bus.oaddr, bus.odata});
            if (bus.ospi_wr) spi_q.push_back(bus.ospi_data);
            if (bus.done) done_cnt++;
        end
        ce = ce_off ? 1'b0 : ce_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    task automatic clr();
        wr_q.delete();
        spi_q.delete();
        done_cnt = 0;
    endtask

    task automatic accept(input bit d, input logic [15:0] a, input logic [3:0] nb);
        @(negedge clk);
        bus.dir = d;
        bus.iaddr = a;
        bus.nblocks = nb;
        bus.start = 1'b1;
        do @(posedge clk); while (!ce);
        clr();
        @(negedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic run_xfer(input bit d, input logic [15:0] a, input logic [3:0] nb,
                            input int stall_at, input bit poke, input int exp_cyc);
        logic [7:0] rx0 = rx_n;
        int k = 0;
        bit s_done = 1'b0;
        bit p_done = 1'b0;
        int n1, n2;
        logic [7:0] eb;
        accept(d, a, nb);
        while (done_cnt == 0 && k < 4000) begin
            if (stall_at >= 0 && !s_done && spi_q.size() == stall_at) begin
                s_done = 1'b1;
                stall = 1'b1;
                n1 = spi_q.size();
                n2 = wr_q.size();
                repeat (20) @(negedge clk);
                #1;
                check("stall_spi", spi_q.size(), n1);
                check("stall_wr", wr_q.size(), n2);
                stall = 1'b0;
            end
            if (poke && !p_done && spi_q.size() == 3) begin
                p_done = 1'b1;
                bus.start = 1'b1;
                bus.iaddr = a + 16'h1234;
                bus.dir = !d;
                bus.nblocks = 4'hF;
                repeat (3) @(negedge clk);
                #1;
                bus.start = 1'b0;
            end
            @(negedge clk);
            #1;
            k++;
        end
        check("done_seen", done_cnt != 0, 1);
        if (exp_cyc >= 0) check("latency", k, exp_cyc);
        repeat (3) @(negedge clk);
        #1;
        check("done_once", done_cnt, 1);
        check("ready_end", bus.ready, 1);
        check("oblocks_end", bus.oblocks, 0);
        check("wr_count", wr_q.size(), d ? 0 : int'(nb) * BB);
        check("spi_count", spi_q.size(), int'(nb) * (BB + TR));
        for (int b = 0; b < int'(nb); b++) begin
            for (int i = 0; i < BB + TR; i++) begin
                int idx = b * (BB + TR) + i;
                int w = b * BB + i;
                logic [15:0] ea = a + 16'(w);
                eb = (i < BB && d) ? mem[ea] : 8'hFF;
                if (idx < spi_q.size()) check("spi_byte", spi_q[idx], eb);
                if (!d && i < BB && w < wr_q.size()) check("wr_entry", wr_q[w], {ea, 8'(rx0 + 8'(idx))});
            end
        end
    endtask

    task automatic run_abort(input logic [15:0] a);
        logic [7:0] rx0 = rx_n;
        int k = 0;
        accept(1'b0, a, 4'd3);
        while (wr_q.size() < 2 && k < 1000) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("abort_reach", wr_q.size(), 2);
        repeat (3) @(negedge clk);
        #1;
        bus.abort = 1'b1;
        @(negedge clk);
        #1;
        bus.abort = 1'b0;
        check("abort_ready", bus.ready, 1);
        check("abort_oblocks", bus.oblocks, 0);
        check("abort_owren", bus.owren, 0);
        repeat (10) @(negedge clk);
        #1;
        check("abort_wr", wr_q.size(), 2);
        check("abort_spi", spi_q.size(), 3);
        check("abort_done", done_cnt, 0);
        if (wr_q.size() >= 2) begin
            check("abort_wr0", wr_q[0], {a, rx0});
            check("abort_wr1", wr_q[1], {a + 16'd1, 8'(rx0 + 8'd1)});
        end
    endtask

    initial begin
        logic [15:0] ra;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) mem[16'h0800 + i] = 8'hA0 + 8'(i);
        bus.start = 1'b1;
        bus.abort = 1'b0;
        bus.dir = 1'b0;
        bus.iaddr = '0;
        bus.nblocks = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", bus.ready, 1);
        check("rst_done", bus.done, 0);
        check("rst_owren", bus.owren, 0);
        check("rst_spi_wr", bus.ospi_wr, 0);
        check("rst_oaddr", bus.oaddr, 0);
        check("rst_odata", bus.odata, 0);
        check("rst_spi_data", bus.ospi_data, 8'hFF);
        check("rst_oblocks", bus.oblocks, 0);
        ce_off = 1'b1;
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("ce_off_ready", bus.ready, 1);
        check("ce_off_done", bus.done, 0);
        clr();
        ce_off = 1'b0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        bus.start = 1'b0;
        check("zero_done", bus.done, 1);
        @(negedge clk);
        #1;
        check("zero_done_fall", bus.done, 0);
        check("zero_done_cnt", done_cnt, 1);
        check("zero_strobes", wr_q.size() + spi_q.size(), 0);

        run_xfer(1'b0, 16'hFFFE, 4'd2, -1, 1'b0, 44);
        run_xfer(1'b1, 16'h0800, 4'd1, -1, 1'b0, 26);

        @(negedge clk);
        #1;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.nblocks = 4'd2;
        @(posedge clk);
        clr();
        @(negedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("sa_ready", bus.ready, 1);
        repeat (6) @(negedge clk);
        #1;
        check("sa_strobes", wr_q.size() + spi_q.size() + done_cnt, 0);
        check("sa_oblocks", bus.oblocks, 0);

        run_xfer(1'b0, 16'h0100, 4'd1, 2, 1'b0, -1);
        run_abort(16'h0200);
        repeat (10) @(negedge clk);
        run_xfer(1'b1, 16'h0300, 4'd2, -1, 1'b1, -1);
        run_xfer(1'b0, 16'h0400, 4'd0, -1, 1'b0, 0);

        ce_rand = 1'b1;
        dly_rand = 1'b1;
        for (int t = 0; t < 12; t++) begin
            ra = $urandom_range(0, 1) ? 16'hFFF0 + 16'($urandom_range(0, 15)) : 16'($urandom);
            run_xfer(1'($urandom_range(0, 1)), ra, 4'($urandom_range(0, 3)), -1, 1'b0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_dma_pump.md
# spi_dma_pump

Parametrised block-transfer engine between the floppy workhorse's SPI master and its memory bus, successor to the single-direction SD-read pump. It moves `nblocks` blocks of `BLOCK_BYTES` bytes in either direction: SPI→memory (card read) or memory→SPI (card write). It appends `TRAILER` filler/CRC bytes per block. While busy it owns the memory bus and the SPI data port; the toplevel muxes them back to the 6502 when `ready`=1.

## Interface
- `AW`, 16, memory address width
- `BLOCK_BYTES`, 512, bytes per block (power of two, ≥2)
- `NBLK_W`, 4, width of block count
- `TRAILER`, 2, extra SPI bytes clocked after each block (0 allowed)
- `FILL`, 8'hFF, byte sent on SPI for read-direction and trailer bytes

Ports:
- `clk` in 1: system clock
- `reset_n` in 1: one clock; reset is asynchronous and active-low
- `ce` in 1: clock enable; all state advances only when `ce`=1
- `start` in 1: sampled when `ce`=1; begins a transfer if idle; ignored while busy
- `abort` in 1: terminates the transfer in progress
- `dir` in 1: 0 = SPI→memory, 1 = memory→SPI; latched at start
- `iaddr` in AW: start address, latched at start
- `nblocks` in NBLK_W: block count, latched at start
- `ready` out 1: 1 when idle
- `done` out 1: one-ce-cycle pulse at normal completion
- `oaddr` out AW: memory address
- `odata` out 8: memory write data
- `owren` out 1: memory write strobe
- `idata` in 8: memory read data, valid one ce-cycle after `oaddr`
- `ospi_data` out 8: byte to SPI
- `ospi_wr` out 1: SPI write strobe, one ce-cycle wide
- `ispi_data` in 8: SPI received byte
- `ispi_dsr` in 1: SPI idle, last received byte valid
- `oblocks` out NBLK_W: blocks remaining, including the current one

## Operation
- States: IDLE, FETCH, LATCH, ISSUE, GUARD, WAIT, STORE.
- IDLE → on `start`: latch `dir`, `iaddr`, `nblocks`; zero the byte counter (log2(BLOCK_BYTES) bits) and the trailer counter.
  - If `nblocks`=0: pulse `done` next ce-cycle and stay in IDLE.
  - Otherwise go to FETCH (dir=1) or ISSUE (dir=0).
- Read direction (dir=0), per byte:
  - ISSUE: `ospi_wr`=1, `ospi_data`=FILL.
  - GUARD: one unconditional cycle, which covers SPI dsr fall latency.
  - WAIT: hold until `ispi_dsr`=1.
  - STORE: `owren`=1, `odata`=`ispi_data`, `oaddr`=current address. Address increments after STORE.
- Write direction (dir=1), per byte:
  - FETCH: present `oaddr`.
  - LATCH: capture `idata` into `ospi_data`; address increments.
  - ISSUE: `ospi_wr`=1.
  - GUARD, then WAIT until `ispi_dsr`=1.
- Trailer: after the last data byte of each block, TRAILER bytes run ISSUE(FILL)→GUARD→WAIT in both directions. Nothing is stored or fetched, and the address does not advance.
- After the trailer, `oblocks` decrements. At 0: `done` pulse, go to IDLE. Otherwise start the next block.
- Address arithmetic is modulo 2^AW, so it wraps from all-ones to 0. The byte counter wraps naturally at the block boundary.
- `abort` (ce=1) in any busy state:
  - Go to IDLE on that edge; no `owren`/`ospi_wr` in or after that cycle; no `done`.
  - `oblocks` clears to 0.
  - An SPI byte already in flight is left to complete, unobserved.
- `start` and `abort` together while idle: abort wins, no transfer.

## Timing
- Reset values: `ready`=1, `done`=0, `owren`=0, `ospi_wr`=0, `oaddr`=0, `odata`=0, `ospi_data`=FILL, `oblocks`=0.
- All outputs are registered. `ready` falls on the ce-edge that accepts `start` and rises on the edge that asserts `done`.
- Minimum ce-cycles per byte, with `ispi_dsr` already 1 in WAIT:
  - read: 4
  - write: 5
  - trailer: 3
- Every strobe (`ospi_wr`, `owren`, `done`) is high for exactly one ce-qualified cycle. When `ce`=0, outputs hold.
- First `ospi_wr` (dir=0) appears the ce-cycle after `start` is accepted. The first `oaddr` in FETCH (dir=1) is also presented that cycle.

## Test plan
- Reset with `start` held high → all outputs at reset values; after release, `ready`=1 until `ce`=1 samples `start`.
- BLOCK_BYTES=4, TRAILER=2, dir=0, iaddr=16'hFFFE, nblocks=2, SPI model returns 8'h10+n:
  - writes at FFFE, FFFF, 0000, …, 0005 with data 10, 11, 12, 13, then 16… (trailer bytes skipped);
  - 12 `ospi_wr` all FILL; one `done`.
- dir=1, iaddr=16'h0800, nblocks=1, memory holds A0..A3 → SPI sees A0, A1, A2, A3, FF, FF; no `owren`; `done` once.
- `ispi_dsr` held 0 for 20 cycles in WAIT → no progress, no extra strobes; resumes on dsr=1.
- `abort` during STORE of byte 2 → that write suppressed, `ready`=1 next cycle, `oblocks`=0, no `done`.
- nblocks=0 → `done` one ce-cycle after start, zero SPI/memory strobes; `start` pulsed mid-transfer → ignored, address sequence unchanged.
